// File: rtl/hjreg_bridge.sv
// Byte-stream to register-bus initiator: parses read/write command frames,
// issues one regreq transaction each, and returns a status (+ read data) frame.
module hjreg_bridge #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rxdata,
    input  logic        rxvalid,
    output logic        rxready,
    output logic [7:0]  txdata,
    output logic        txvalid,
    input  logic        txready,
    output logic        regreq,
    output logic        regwr,
    output logic [15:0] regaddr,
    output logic [31:0] regwdata,
    input  logic        regack,
    input  logic        regerr,
    input  logic [31:0] regrdata,
    output logic        busy
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;
    // The first WAIT cycle is one cycle after regreq, so the last waiting
    // cycle is reached when the count equals TIMEOUT-2.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 2);

    localparam logic [7:0] OP_READ   = 8'h01;
    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] ST_OK     = 8'h00;
    localparam logic [7:0] ST_REGERR = 8'h01;
    localparam logic [7:0] ST_TMO    = 8'h02;
    localparam logic [7:0] ST_BADOP  = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_REQ, S_WAIT, S_RESP, S_RDATA
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_bcnt;
    logic [31:0]   r_rd;
    logic [7:0]    r_status;

    logic w_rx_take;
    logic w_tx_done;

    assign w_rx_take = rxvalid && rxready;
    assign w_tx_done = txvalid && txready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bcnt   <= '0;
            r_rd     <= '0;
            r_status <= '0;
            rxready  <= 1'b0;
            txvalid  <= 1'b0;
            txdata   <= '0;
            regreq   <= 1'b0;
            regwr    <= 1'b0;
            regaddr  <= '0;
            regwdata <= '0;
            busy     <= 1'b0;
        end else begin
            regreq <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    rxready <= 1'b1;
                    if (w_rx_take) begin
                        busy <= 1'b1;
                        if (rxdata == OP_READ || rxdata == OP_WRITE) begin
                            regwr   <= (rxdata == OP_WRITE);
                            r_bcnt  <= '0;
                            r_state <= S_ADDR;
                        end else begin
                            rxready  <= 1'b0;
                            r_status <= ST_BADOP;
                            txdata   <= ST_BADOP;
                            txvalid  <= 1'b1;
                            r_state  <= S_RESP;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_rx_take) begin
                        regaddr <= {regaddr[7:0], rxdata};
                        r_bcnt  <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd1) begin
                            r_bcnt <= '0;
                            if (regwr) begin
                                r_state <= S_DATA;
                            end else begin
                                rxready <= 1'b0;
                                regreq  <= 1'b1;
                                r_state <= S_REQ;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (w_rx_take) begin
                        regwdata <= {regwdata[23:0], rxdata};
                        r_bcnt   <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_bcnt  <= '0;
                            rxready <= 1'b0;
                            regreq  <= 1'b1;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (regack) begin
                        r_rd     <= regrdata;
                        r_status <= regerr ? ST_REGERR : ST_OK;
                        txdata   <= regerr ? ST_REGERR : ST_OK;
                        txvalid  <= 1'b1;
                        r_state  <= S_RESP;
                    end else if (r_cnt >= TO_LAST) begin
                        r_status <= ST_TMO;
                        txdata   <= ST_TMO;
                        txvalid  <= 1'b1;
                        r_state  <= S_RESP;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (w_tx_done) begin
                        if (!regwr && r_status == ST_OK) begin
                            txdata  <= r_rd[31:24];
                            r_rd    <= {r_rd[23:0], 8'h00};
                            r_bcnt  <= '0;
                            r_state <= S_RDATA;
                        end else begin
                            txvalid <= 1'b0;
                            busy    <= 1'b0;
                            rxready <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_RDATA: begin
                    if (w_tx_done) begin
                        if (r_bcnt == 2'd3) begin
                            r_bcnt  <= '0;
                            txvalid <= 1'b0;
                            busy    <= 1'b0;
                            rxready <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            txdata <= r_rd[31:24];
                            r_rd   <= {r_rd[23:0], 8'h00};
                            r_bcnt <= r_bcnt + 2'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hjreg_bridge.sv
// Scoreboard bench for hjreg_bridge: directed command frames, queued expected
// register transactions and response bytes, checked by independent monitors.
module tb_hjreg_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rxdata = 8'h00;
    logic        rxvalid = 1'b0;
    logic        rxready;
    logic [7:0]  txdata;
    logic        txvalid;
    logic        txready = 1'b1;
    logic        regreq;
    logic        regwr;
    logic [15:0] regaddr;
    logic [31:0] regwdata;
    logic        regack = 1'b0;
    logic        regerr = 1'b0;
    logic [31:0] regrdata = 32'h0;
    logic        busy;

    hjreg_bridge #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .rxdata(rxdata), .rxvalid(rxvalid), .rxready(rxready),
        .txdata(txdata), .txvalid(txvalid), .txready(txready),
        .regreq(regreq), .regwr(regwr), .regaddr(regaddr), .regwdata(regwdata),
        .regack(regack), .regerr(regerr), .regrdata(regrdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        chkw;
    } req_t;

    req_t       exp_req[$];
    logic [7:0] exp_tx[$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    int unsigned last_req_cyc = 0;
    int unsigned tx_count = 0;
    int unsigned inject_cnt = 0;

    logic        ack_enable = 1'b1;
    int unsigned ack_delay  = 1;
    logic        resp_err   = 1'b0;
    logic [31:0] resp_data  = 32'h0;

    logic        cap_wr;
    logic [15:0] cap_addr;
    logic [31:0] cap_wdata;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // response-byte monitor
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (txvalid && txready) begin
                tx_count++;
                if (exp_tx.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_tx: got %02h expected none", txdata);
                end else begin
                    e = exp_tx.pop_front();
                    chk("tx_byte", {56'h0, txdata}, {56'h0, e});
                end
            end
        end
    end

    // register-request monitor
    initial begin
        req_t r;
        forever begin
            @(negedge clk);
            if (regreq) begin
                last_req_cyc = cyc;
                cap_wr    = regwr;
                cap_addr  = regaddr;
                cap_wdata = regwdata;
                if (exp_req.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_regreq: got addr %04h expected none", regaddr);
                end else begin
                    r = exp_req.pop_front();
                    chk("regwr", {63'h0, regwr}, {63'h0, r.wr});
                    chk("regaddr", {48'h0, regaddr}, {48'h0, r.addr});
                    if (r.chkw) chk("regwdata", {32'h0, regwdata}, {32'h0, r.wdata});
                end
            end
        end
    end

    // responder, plus out-of-window ack injection on request
    initial begin
        int unsigned seen = 0;
        forever begin
            @(negedge clk);
            if (regreq && ack_enable) begin
                repeat (ack_delay) @(posedge clk);
                #1;
                regack = 1'b1; regerr = resp_err; regrdata = resp_data;
                @(negedge clk);
                chk("hold_regwr", {63'h0, regwr}, {63'h0, cap_wr});
                chk("hold_regaddr", {48'h0, regaddr}, {48'h0, cap_addr});
                chk("hold_regwdata", {32'h0, regwdata}, {32'h0, cap_wdata});
                @(posedge clk);
                #1;
                regack = 1'b0; regerr = 1'b0; regrdata = 32'h0;
            end else if (inject_cnt != seen) begin
                seen = inject_cnt;
                @(posedge clk);
                #1;
                regack = 1'b1; regerr = 1'b1; regrdata = 32'hFFFF_FFFF;
                @(posedge clk);
                #1;
                regack = 1'b0; regerr = 1'b0; regrdata = 32'h0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int unsigned n;
        @(posedge clk);
        #1;
        rxdata = b; rxvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rxready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rxready) begin
            n_checks++;
            $display("FAIL rx_accept: byte %02h not accepted within 200 cycles", b);
        end
        @(posedge clk);
        #1;
        rxvalid = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a);
        send_byte(8'h01); send_byte(a[15:8]); send_byte(a[7:0]);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d);
        send_byte(8'h02); send_byte(a[15:8]); send_byte(a[7:0]);
        send_byte(d[31:24]); send_byte(d[23:16]); send_byte(d[15:8]); send_byte(d[7:0]);
    endtask

    task automatic push_req(input logic wr, input logic [15:0] a, input logic [31:0] d, input logic cw);
        req_t r;
        r.wr = wr; r.addr = a; r.wdata = d; r.chkw = cw;
        exp_req.push_back(r);
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy == 1'b0 && exp_tx.size() == 0) && n < 500);
        if (n >= 500) begin
            n_checks++;
            $display("FAIL wait_idle: busy %0b, %0d bytes outstanding after 500 cycles", busy, exp_tx.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected < 200000", $time);
        $fatal(1);
    end

    initial begin
        int unsigned n;
        int unsigned t0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {37'h0, rxready, txvalid, txdata, regreq, regwr, regaddr, busy},
            64'h0);
        chk("reset_wdata", {32'h0, regwdata}, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_rxready", {63'h0, rxready}, 64'h1);

        // 1: write, ack 3 cycles after regreq
        ack_delay = 3; resp_err = 1'b0;
        push_req(1'b1, 16'h000C, 32'hDEADBEEF, 1'b1);
        exp_tx.push_back(8'h00);
        do_write(16'h000C, 32'hDEADBEEF);
        wait_idle();

        // 2: read, ack 1 cycle after regreq
        ack_delay = 1; resp_data = 32'h0000_0020;
        push_req(1'b0, 16'h0004, 32'h0, 1'b0);
        exp_tx.push_back(8'h00); exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h00); exp_tx.push_back(8'h20);
        do_read(16'h0004);
        wait_idle();

        // 3: read rejected by responder
        ack_delay = 2; resp_err = 1'b1; resp_data = 32'hCAFE_F00D;
        push_req(1'b0, 16'h0010, 32'h0, 1'b0);
        exp_tx.push_back(8'h01);
        do_read(16'h0010);
        wait_idle();
        resp_err = 1'b0;

        // 4: timeout, then a late ack that must be ignored
        ack_enable = 1'b0;
        push_req(1'b0, 16'h0040, 32'h0, 1'b0);
        exp_tx.push_back(8'h02);
        do_read(16'h0040);
        n = 0;
        while (!txvalid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", 64'(cyc - last_req_cyc), 64'd16);
        repeat (5) @(negedge clk);
        inject_cnt++;
        repeat (6) @(negedge clk);
        chk("late_ack_busy", {63'h0, busy}, 64'h0);
        chk("late_ack_txvalid", {63'h0, txvalid}, 64'h0);
        chk("late_ack_rxready", {63'h0, rxready}, 64'h1);
        ack_enable = 1'b1;
        wait_idle();

        // 5: bad opcode, then a normal read
        exp_tx.push_back(8'h03);
        send_byte(8'h7F);
        ack_delay = 1; resp_data = 32'h1234_5678;
        push_req(1'b0, 16'h0000, 32'h0, 1'b0);
        exp_tx.push_back(8'h00); exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
        exp_tx.push_back(8'h56); exp_tx.push_back(8'h78);
        do_read(16'h0000);
        wait_idle();

        // 6a: backpressure during RDATA
        ack_delay = 2; resp_data = 32'hA5B6_C7D8;
        push_req(1'b0, 16'h0020, 32'h0, 1'b0);
        exp_tx.push_back(8'h00); exp_tx.push_back(8'hA5); exp_tx.push_back(8'hB6);
        exp_tx.push_back(8'hC7); exp_tx.push_back(8'hD8);
        t0 = tx_count;
        do_read(16'h0020);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (tx_count == t0 && n < 100);
        @(posedge clk);
        #1;
        txready = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("bp_txdata", {56'h0, txdata}, 64'hA5);
            chk("bp_txvalid", {63'h0, txvalid}, 64'h1);
        end
        @(posedge clk);
        #1;
        txready = 1'b1;
        wait_idle();

        // 6b: reset while waiting for ack, then a normal write
        ack_enable = 1'b0;
        push_req(1'b0, 16'h0008, 32'h0, 1'b0);
        do_read(16'h0008);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wait_outputs", {37'h0, rxready, txvalid, txdata, regreq, regwr, regaddr, busy},
            64'h0);
        chk("rst_wait_wdata", {32'h0, regwdata}, 64'h0);
        ack_enable = 1'b1; ack_delay = 2;
        push_req(1'b1, 16'h1234, 32'h0000_005A, 1'b1);
        exp_tx.push_back(8'h00);
        do_write(16'h1234, 32'h0000_005A);
        wait_idle();

        chk("tx_queue_empty", 64'(exp_tx.size()), 64'd0);
        chk("req_queue_empty", 64'(exp_req.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
